// File: rtl/rr_arb_mux.sv
// rr_arb_mux: NUM_CH-channel, WIDTH-bit arbitrated mux with valid/ready on every side.
// Arbitration is fixed priority (RR_EN=0, channel 0 highest) or round-robin (RR_EN=1).
// A single output register gives one-cycle latency and full throughput.
// Optional packet lock with last_i/last_o is enabled by defining RR_ARB_MUX_LAST_EN.
module rr_arb_mux #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned RR_EN  = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       req_i,
  input  logic [NUM_CH*WIDTH-1:0] data_i,
`ifdef RR_ARB_MUX_LAST_EN
  input  logic [NUM_CH-1:0]       last_i,
  output logic                    last_o,
`endif
  output logic [NUM_CH-1:0]       ready_o,
  output logic                    valid_o,
  output logic [WIDTH-1:0]        data_o,
  output logic [NUM_CH-1:0]       gnt_o,
  input  logic                    ready_i
);

  localparam int unsigned PtrW = $clog2(NUM_CH);

  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;

  logic              load;
  logic              found;
  logic [PtrW-1:0]   win_idx;
  logic [NUM_CH-1:0] win;
  logic              xfer;
  logic              advance;
  logic [PtrW-1:0]   ptr_next;

  logic [WIDTH-1:0]  ch_data [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch_data
    assign ch_data[g] = data_i[g*WIDTH +: WIDTH];
  end

`ifdef RR_ARB_MUX_LAST_EN
  logic            lock_q, lock_d;
  logic [PtrW-1:0] lock_ch_q, lock_ch_d;
  logic            last_q, last_d;
`endif

  // Output register can take a new beat when empty or being drained this cycle
  assign load = ~valid_q | ready_i;

  // Arbitration: scan from ptr (round-robin) or from 0 (fixed priority), first requester wins
  always_comb begin
    int unsigned     k;
    logic [PtrW-1:0] start;
    k       = 0;
    found   = 1'b0;
    win_idx = '0;
    start   = (RR_EN != 0) ? ptr_q : '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      k = i + 32'(start);
      if (k >= NUM_CH) k = k - NUM_CH;
      if (!found && req_i[PtrW'(k)]) begin
        found   = 1'b1;
        win_idx = PtrW'(k);
      end
    end
`ifdef RR_ARB_MUX_LAST_EN
    // Mid-packet only the owning channel may win, even if it is idle this cycle
    if (lock_q) begin
      found   = req_i[lock_ch_q];
      win_idx = lock_ch_q;
    end
`endif
    win = '0;
    win[win_idx] = found;
  end

  assign ready_o  = win & {NUM_CH{load & reset_n}};
  assign xfer     = load & found;
  assign ptr_next = (win_idx == PtrW'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;

`ifdef RR_ARB_MUX_LAST_EN
  assign advance = last_i[win_idx];
`else
  assign advance = 1'b1;
`endif

  // Next-state for the output register and the round-robin pointer
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    if (load) begin
      if (found) begin
        valid_d = 1'b1;
        data_d  = ch_data[win_idx];
        gnt_d   = win;
        if ((RR_EN != 0) && advance) ptr_d = ptr_next;
      end else begin
        valid_d = 1'b0;
        gnt_d   = '0;
      end
    end
  end

`ifdef RR_ARB_MUX_LAST_EN
  // Packet lock tracking: a non-last beat claims the mux for its channel
  always_comb begin
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    last_d    = last_q;
    if (xfer) begin
      lock_d    = ~last_i[win_idx];
      lock_ch_d = win_idx;
      last_d    = last_i[win_idx];
    end
  end

  // Lock state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
      last_q    <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
      last_q    <= last_d;
    end
  end

  assign last_o = last_q;
`endif

  // Output stage and pointer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign gnt_o   = gnt_q;

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-channel, W-bit arbitrated multiplexer with valid/ready handshakes on every input and on the output.
- Generalises the one-hot/priority 4:1 bit mux to NUM_CH channels of WIDTH bits.
- Selection is by fixed priority or by round-robin arbitration, chosen at elaboration.
- A single registered output stage gives one-cycle latency and full throughput. It sits between multiple producers and one shared downstream consumer.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- WIDTH, 8, data width per channel in bits.
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with channel 0 highest.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_i  input  NUM_CH  per-channel valid; bit k means data on channel k is offered.
- data_i  input  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- ready_o  output  NUM_CH  per-channel accept, combinational, at most one bit high.
- valid_o  output  1  output register holds a beat.
- data_o  output  WIDTH  registered data of the held beat.
- gnt_o  output  NUM_CH  one-hot index of the channel that supplied the held beat; 0 when empty.
- ready_i  input  1  downstream accept.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - valid_o=0, data_o=0, gnt_o=0.
  - Round-robin pointer ptr=0.
  - ready_o=0 while reset is asserted.
- Load enable: load = !valid_o | ready_i.
- Arbitration runs combinationally every cycle over req_i:
  - RR_EN=0: lowest-index requesting channel wins.
  - RR_EN=1: search starts at ptr and wraps modulo NUM_CH; the first requester found wins.
- ready_o[k] = load & win[k]. A channel beat transfers when req_i[k] & ready_o[k].
- On a transfer:
  - Next edge: valid_o=1, data_o=data_i[k], gnt_o=one-hot(k).
  - With RR_EN=1, ptr <= (k+1) mod NUM_CH.
- If load=1 and there is no request: valid_o <= 0 and gnt_o <= 0. data_o holds its last value. ptr is unchanged.
- If valid_o=1 and ready_i=0 (stall): valid_o, data_o and gnt_o hold stable, all ready_o=0, ptr is unchanged.
- Latency is 1 cycle from input transfer to valid_o. Sustained throughput is 1 beat/cycle when ready_i=1.
- Simultaneous output accept and new request in the same cycle: the output is replaced back-to-back with no bubble.
- ptr wraps from NUM_CH-1 to 0.
- A requester whose req_i drops before it is granted is simply skipped; no state is retained for it.
- Reset mid-stall: the held beat is discarded and valid_o drops immediately.
- With RR_EN=1, every continuously requesting channel is granted within NUM_CH transfers.

Optional Feature:
Macro: RR_ARB_MUX_LAST_EN
- Defined:
  - Adds input last_i [NUM_CH] and output last_o [1]. last_o is registered with data_o and resets to 0.
  - Packet lock: once channel k transfers a beat with last_i[k]=0, only channel k may win until it transfers a beat with last_i[k]=1.
  - ptr advances only on that last beat. RR_EN=0 obeys the same lock.
  - While locked and req_i[k]=0, no channel is granted, even if others request.
  - Reset clears the lock.
- Undefined:
  - The last_i and last_o ports are absent.
  - Every beat is arbitrated independently.

Test Plan (NUM_CH=4, WIDTH=8 unless noted):
1. Reset then idle: hold reset_n=0 for 3 cycles, release with req_i=0 -> valid_o=0, gnt_o=0, data_o=0, ready_o=0 every cycle.
2. RR_EN=1, req_i=4'b1111 constant, data_i={8'h33,8'h22,8'h11,8'h00}, ready_i=1 -> data_o sequence 00,11,22,33,00 on consecutive cycles, gnt_o 0001,0010,0100,1000,0001.
3. RR_EN=0, same stimulus -> data_o=00 and gnt_o=0001 every cycle, ready_o=4'b0001.
4. Stall: valid_o=1, data_o=8'h22, ready_i=0 for 5 cycles while req_i=4'b1111 -> data_o stays 22, ready_o=0, ptr is unchanged. When ready_i=1, the next beat is 33 on the following cycle.
5. Single channel: req_i=4'b0100 only, data_i[2]=8'hA5, ready_i=1 -> ready_o=4'b0100 each cycle, data_o=A5, gnt_o=0100. Dropping req_i gives valid_o=0 one cycle later.
6. RR_ARB_MUX_LAST_EN defined: ch1 sends 3 beats with last=0,0,1 while ch0 and ch2 request -> three consecutive ch1 beats with last_o=0,0,1, then ch2 is granted next.
